perf_event_monitor: RTL and testbench

PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

---
 rtl/perf_pkg.sv | 21 ++
 rtl/sat_counter.sv | 55 +++++
 rtl/perf_event_monitor.sv | 142 ++++++++++++++
 tb/tb_perf_event_monitor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perf_pkg
//  Description : Shared FSM state encoding and read-select codes for the
//                performance event monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Monitor run-control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Read-select code that returns the cycle counter; event channel k is k+1
    localparam int unsigned c_SEL_CYCLE = 0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear, optional
//                "discard first event" skip flag and sticky saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import perf_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SKIP_INIT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_cnt;
    logic             r_sat;
    logic             r_skip;

    // Count qualified increments; a pending skip swallows the first one,
    // and the sticky flag is raised on the increment that reaches the ceiling
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_skip <= SKIP_INIT;
        end else if (clr_i) begin
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_skip <= SKIP_INIT;
        end else if (inc_i) begin
            if (r_skip) begin
                r_skip <= 1'b0;
            end else if (r_cnt != c_MAX) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_MAX - 1'b1) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign cnt_o = r_cnt;
    assign sat_o = r_sat;

endmodule
`default_nettype wire

// File: rtl/perf_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : perf_event_monitor
//  Description : Counts per-channel event strobes and elapsed cycles over a
//                start-gated run window, with freeze, clear, saturation and a
//                registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int                 NUM_EVT     = 2,
    parameter int                 CNT_W       = 32,
    parameter int                 CYCLE_LIMIT = 100,
    parameter logic [NUM_EVT-1:0] SKIP_MASK   = NUM_EVT'(1)
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               start_i,
    input  logic [NUM_EVT-1:0]                 evt_i,
    input  logic                               clear_i,
    input  logic                               freeze_i,
    input  logic [$clog2(NUM_EVT+1)-1:0]       rd_sel_i,
    output logic [CNT_W-1:0]                   rd_data_o,
    output logic [NUM_EVT-1:0]                 sat_o,
    output logic                               done_o
);

    localparam int               c_SEL_W     = $clog2(NUM_EVT + 1);
    localparam bit               c_HAS_LIMIT = (CYCLE_LIMIT != 0);
    // Cycle count seen on the edge that completes the run
    localparam logic [CNT_W-1:0] c_LAST      = CNT_W'(CYCLE_LIMIT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_cyc_cnt;
    logic               w_unused_cyc_sat;
    logic [CNT_W-1:0]   w_evt_cnt [NUM_EVT];
    logic [NUM_EVT-1:0] w_evt_sat;
    logic [CNT_W-1:0]   w_rd_mux;
    logic [CNT_W-1:0]   r_rd_data;

    // Run-control state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and count enable; counting only happens on a RUN edge that
    // keeps start high and is not frozen, so dropping start holds the counts
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_en    = 1'b0;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!freeze_i) begin
                        w_cnt_en = 1'b1;
                        if (c_HAS_LIMIT && (w_cyc_cnt == c_LAST)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH     (CNT_W),
        .SKIP_INIT (1'b0)
    ) u_cyc_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (clear_i),
        .inc_i   (w_cnt_en),
        .cnt_o   (w_cyc_cnt),
        .sat_o   (w_unused_cyc_sat)
    );

    generate
        for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
            sat_counter #(
                .WIDTH     (CNT_W),
                .SKIP_INIT (SKIP_MASK[k])
            ) u_evt_cnt (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .clr_i   (clear_i),
                .inc_i   (w_cnt_en & evt_i[k]),
                .cnt_o   (w_evt_cnt[k]),
                .sat_o   (w_evt_sat[k])
            );
        end
    endgenerate

    // Read-select mux over pre-update counter values; unknown codes read 0
    always_comb begin
        w_rd_mux = '0;
        if (rd_sel_i == c_SEL_W'(c_SEL_CYCLE)) begin
            w_rd_mux = w_cyc_cnt;
        end
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_sel_i == c_SEL_W'(k + 1)) begin
                w_rd_mux = w_evt_cnt[k];
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data_o = r_rd_data;
    assign sat_o     = w_evt_sat;
    assign done_o    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_event_monitor
//  Description : Self-checking bench for perf_event_monitor. Two instances
//                (32-bit with a 100-cycle limit, 8-bit without a limit) share
//                one stimulus stream and are compared every cycle against a
//                behavioural model, plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_event_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  evt = 2'b00;
    logic [1:0]  rd_sel = 2'd0;

    logic [31:0] rd0;
    logic [7:0]  rd8;
    logic [1:0]  sat0;
    logic [1:0]  sat8;
    logic        done0;
    logic        done8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_event_monitor #(
        .NUM_EVT     (2),
        .CNT_W       (32),
        .CYCLE_LIMIT (100),
        .SKIP_MASK   (2'b01)
    ) dut0 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .evt_i     (evt),
        .clear_i   (clear),
        .freeze_i  (freeze),
        .rd_sel_i  (rd_sel),
        .rd_data_o (rd0),
        .sat_o     (sat0),
        .done_o    (done0)
    );

    perf_event_monitor #(
        .NUM_EVT     (2),
        .CNT_W       (8),
        .CYCLE_LIMIT (0),
        .SKIP_MASK   (2'b01)
    ) dut8 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .evt_i     (evt),
        .clear_i   (clear),
        .freeze_i  (freeze),
        .rd_sel_i  (rd_sel),
        .rd_data_o (rd8),
        .sat_o     (sat8),
        .done_o    (done8)
    );

    // ---------------- behavioural model (index 0 = dut0, 1 = dut8) ----------
    // m_st: 0 idle, 1 run, 2 done
    int              m_st   [2];
    longint unsigned m_cyc  [2];
    longint unsigned m_rd   [2];
    longint unsigned m_cnt  [2][2];
    bit              m_skip [2][2];

    function automatic longint unsigned max_of(int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'hFF;
    endfunction

    function automatic longint unsigned lim_of(int i);
        return (i == 0) ? 64'd100 : 64'd0;
    endfunction

    function automatic longint unsigned m_read(int i, int sel);
        if (sel == 0) return m_cyc[i];
        if (sel == 1 || sel == 2) return m_cnt[i][sel-1];
        return 64'd0;
    endfunction

    task automatic model_clear(int i);
        m_st[i]  = 0;
        m_cyc[i] = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[i][k]  = 0;
            m_skip[i][k] = (k == 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            m_rd[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = m_read(i, int'(rd_sel));
            if (clear) begin
                model_clear(i);
            end else if (m_st[i] == 0) begin
                if (start) m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                if (!start) begin
                    m_st[i] = 0;
                end else if (!freeze) begin
                    for (int k = 0; k < 2; k++) begin
                        if (evt[k]) begin
                            if (m_skip[i][k]) m_skip[i][k] = 1'b0;
                            else if (m_cnt[i][k] < max_of(i)) m_cnt[i][k] = m_cnt[i][k] + 1;
                        end
                    end
                    if (m_cyc[i] < max_of(i)) m_cyc[i] = m_cyc[i] + 1;
                    if (lim_of(i) != 0 && m_cyc[i] == lim_of(i)) m_st[i] = 2;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- checking ----------------------------------------------
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_sat(int i);
        logic [1:0] s;
        for (int k = 0; k < 2; k++) s[k] = (m_cnt[i][k] == max_of(i));
        return s;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            check("model_rd0",   64'(rd0),   m_rd[0]);
            check("model_rd8",   64'(rd8),   m_rd[1]);
            check("model_sat0",  64'(sat0),  64'(m_sat(0)));
            check("model_sat8",  64'(sat8),  64'(m_sat(1)));
            check("model_done0", 64'(done0), 64'(m_st[0] == 2));
            check("model_done8", 64'(done8), 64'(m_st[1] == 2));
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1; start = 1'b0; evt = 2'b00; freeze = 1'b0;
        tick(1);
        clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        #2 rst_n = 1'b0;
        tick(2);
        check("reset_rd0",   64'(rd0),   64'd0);
        check("reset_sat0",  64'(sat0),  64'd0);
        check("reset_done0", 64'(done0), 64'd0);
        check("reset_rd8",   64'(rd8),   64'd0);
        rst_n = 1'b1;

        // Cycle limit: run 120 cycles without events
        start = 1'b1; rd_sel = 2'd0;
        tick(50);
        check("cyc_mid",  64'(rd0),   64'd48);
        check("done_mid", 64'(done0), 64'd0);
        tick(70);
        check("done_lim",      64'(done0), 64'd1);
        check("cyc_lim",       64'(rd0),   64'd100);
        check("done8_nolimit", 64'(done8), 64'd0);
        tick(5);
        check("cyc_hold", 64'(rd0), 64'd100);

        // Skip on channel 0, plain count on channel 1
        do_clear();
        start = 1'b1;
        tick(2);
        repeat (4) begin evt = 2'b01; tick(1); evt = 2'b00; tick(1); end
        repeat (4) begin evt = 2'b10; tick(1); evt = 2'b00; tick(1); end
        rd_sel = 2'd1; tick(2);
        check("evt0_skip",  64'(rd0), 64'd3);
        check("evt0_skip8", 64'(rd8), 64'd3);
        rd_sel = 2'd2; tick(2);
        check("evt1_count", 64'(rd0), 64'd4);

        // Saturation on the 8-bit instance
        do_clear();
        start = 1'b1; evt = 2'b10; rd_sel = 2'd2;
        tick(301);
        evt = 2'b00;
        tick(2);
        check("sat_cnt8",   64'(rd8),     64'd255);
        check("sat_flag8",  64'(sat8[1]), 64'd1);
        check("sat_flag8b", 64'(sat8[0]), 64'd0);
        do_clear();
        tick(2);
        check("clr_cnt8", 64'(rd8),  64'd0);
        check("clr_sat8", 64'(sat8), 64'd0);

        // Clear beats same-cycle events and re-arms the skip
        start = 1'b1;
        tick(2);
        evt = 2'b01; tick(1); evt = 2'b00; tick(1);
        clear = 1'b1; evt = 2'b11; tick(1);
        clear = 1'b0; evt = 2'b00; rd_sel = 2'd1; tick(2);
        check("clr_evt_c0", 64'(rd0), 64'd0);
        rd_sel = 2'd2; tick(2);
        check("clr_evt_c1", 64'(rd0), 64'd0);
        evt = 2'b01; tick(1); evt = 2'b00; rd_sel = 2'd1; tick(2);
        check("rearm_skip", 64'(rd0), 64'd0);
        evt = 2'b01; tick(1); evt = 2'b00; tick(2);
        check("after_rearm", 64'(rd0), 64'd1);

        // Asynchronous reset in the middle of a run
        do_clear();
        start = 1'b1; evt = 2'b11; rd_sel = 2'd0;
        tick(38);
        #3 rst_n = 1'b0;
        #1;
        check("async_rd0",   64'(rd0),   64'd0);
        check("async_sat0",  64'(sat0),  64'd0);
        check("async_done0", 64'(done0), 64'd0);
        check("async_rd8",   64'(rd8),   64'd0);
        @(negedge clk);
        evt = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("restart_cyc", 64'(rd0), 64'd1);

        // Freeze holds counts and the pending skip
        do_clear();
        start = 1'b1;
        tick(6);
        freeze = 1'b1; evt = 2'b11; rd_sel = 2'd0;
        tick(10);
        check("frz_cyc", 64'(rd0), 64'd5);
        evt = 2'b00; rd_sel = 2'd1; tick(2);
        check("frz_c0", 64'(rd0), 64'd0);
        rd_sel = 2'd2; tick(2);
        check("frz_c1", 64'(rd0), 64'd0);
        freeze = 1'b0; evt = 2'b01; tick(1);
        evt = 2'b00; rd_sel = 2'd1; tick(2);
        check("frz_skip_kept", 64'(rd0), 64'd0);
        evt = 2'b01; tick(1); evt = 2'b00; tick(2);
        check("frz_after", 64'(rd0), 64'd1);

        // Randomised traffic against the model
        repeat (3000) begin
            start  = ($urandom_range(0, 31) != 0);
            clear  = ($urandom_range(0, 63) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            evt    = 2'($urandom_range(0, 3));
            rd_sel = 2'($urandom_range(0, 3));
            tick(1);
        end
        clear = 1'b0; start = 1'b0; freeze = 1'b0; evt = 2'b00;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
